// File: rtl/owl_pixel_gearbox.sv
// owl_pixel_gearbox: repacks the 48-bit / 4-pixel capture stream into 64-bit
// AXI4-Stream words, tags start-of-frame (tuser) and end-of-capture (tlast),
// and buffers the words in a first-word-fall-through FIFO.
module owl_pixel_gearbox #(
   parameter int unsigned FIFO_DEPTH = 512,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             new_frame,
   input  logic [47:0]      pixel,
   input  logic             data_vld,
   input  logic             capture_end,
   output logic [63:0]      m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tuser,
   output logic             m_axis_tlast,
   output logic             overflow,
   output logic [CNT_W-1:0] word_count,
   output logic             frame_done
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH_RES, S_FLUSH_LAST} state_t;

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;        // residue 0 / 48 / 32 / 16 bits
   logic [47:0]      res_q, res_d;            // leftover bits, upper bits kept zero
   logic [63:0]      pend_data_q, pend_data_d;
   logic             pend_user_q, pend_user_d;
   logic             pend_vld_q, pend_vld_d;
   logic             sof_q, sof_d;
   logic             cap_q, cap_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             fdone_q, fdone_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [65:0]      mem [FIFO_DEPTH];

   logic             cap_rise;
   logic             form;
   logic [63:0]      form_data;
   logic             push_req;
   logic [65:0]      push_word;
   logic             push_ok;
   logic             pop;
   logic             full;
   logic [65:0]      rd_word;

   assign cap_rise = capture_end & ~cap_q;
   assign cap_d    = capture_end;

   // Frame FSM, bit packer and pending-word slot
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      res_d       = res_q;
      pend_data_d = pend_data_q;
      pend_user_d = pend_user_q;
      pend_vld_d  = pend_vld_q;
      sof_d       = sof_q;
      fdone_d     = 1'b0;
      form        = 1'b0;
      form_data   = '0;
      push_req    = 1'b0;
      push_word   = '0;
      if (new_frame) begin
         state_d     = S_ACTIVE;
         phase_d     = '0;
         res_d       = '0;
         pend_data_d = '0;
         pend_user_d = 1'b0;
         pend_vld_d  = 1'b0;
         sof_d       = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
            end
            S_ACTIVE: begin
               if (cap_rise) begin
                  state_d = (phase_q != 2'd0) ? S_FLUSH_RES : S_FLUSH_LAST;
               end else if (data_vld) begin
                  case (phase_q)
                     2'd0: res_d = pixel;
                     2'd1: begin
                        form      = 1'b1;
                        form_data = {pixel[15:0], res_q};
                        res_d     = {16'h0, pixel[47:16]};
                     end
                     2'd2: begin
                        form      = 1'b1;
                        form_data = {pixel[31:0], res_q[31:0]};
                        res_d     = {32'h0, pixel[47:32]};
                     end
                     default: begin
                        form      = 1'b1;
                        form_data = {pixel, res_q[15:0]};
                        res_d     = '0;
                     end
                  endcase
                  phase_d = phase_q + 2'd1;
               end
            end
            S_FLUSH_RES: begin
               form      = 1'b1;
               form_data = {16'h0, res_q};
               res_d     = '0;
               phase_d   = '0;
               state_d   = S_FLUSH_LAST;
            end
            S_FLUSH_LAST: begin
               if (pend_vld_q) begin
                  push_req  = 1'b1;
                  push_word = {1'b1, pend_user_q, pend_data_q};
               end
               pend_vld_d = 1'b0;
               fdone_d    = 1'b1;
               state_d    = S_IDLE;
            end
         endcase
         // A newly formed word displaces the held one into the FIFO, so the
         // final word of a capture is always still held when capture_end arrives.
         if (form) begin
            if (pend_vld_q) begin
               push_req  = 1'b1;
               push_word = {1'b0, pend_user_q, pend_data_q};
            end
            pend_vld_d  = 1'b1;
            pend_data_d = form_data;
            pend_user_d = sof_q;
            sof_d       = 1'b0;
         end
      end
   end

   assign full    = (cnt_q == (AW+1)'(FIFO_DEPTH));
   assign pop     = (cnt_q != '0) & m_axis_tready;
   assign push_ok = push_req & (~full | pop);

   // FIFO pointers, occupancy, overflow flag and word counter
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      cnt_d    = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
      ovf_d    = ovf_q | (push_req & ~push_ok);
      wcnt_d   = wcnt_q;
      if (push_ok && (wcnt_q != '1)) begin
         wcnt_d = wcnt_q + CNT_W'(1);
      end
      if (new_frame) begin
         ovf_d  = 1'b0;
         wcnt_d = '0;
      end
   end

   // State registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         res_q       <= '0;
         pend_data_q <= '0;
         pend_user_q <= 1'b0;
         pend_vld_q  <= 1'b0;
         sof_q       <= 1'b0;
         cap_q       <= 1'b0;
         ovf_q       <= 1'b0;
         wcnt_q      <= '0;
         fdone_q     <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         res_q       <= res_d;
         pend_data_q <= pend_data_d;
         pend_user_q <= pend_user_d;
         pend_vld_q  <= pend_vld_d;
         sof_q       <= sof_d;
         cap_q       <= cap_d;
         ovf_q       <= ovf_d;
         wcnt_q      <= wcnt_d;
         fdone_q     <= fdone_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   // FIFO storage, no reset needed
   always_ff @(posedge sys_clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= push_word;
      end
   end

   // Head entry shown directly (fall-through); gated so outputs read zero when empty
   assign rd_word       = mem[rd_ptr_q];
   assign m_axis_tvalid = (cnt_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? rd_word[63:0] : '0;
   assign m_axis_tuser  = m_axis_tvalid & rd_word[64];
   assign m_axis_tlast  = m_axis_tvalid & rd_word[65];
   assign overflow      = ovf_q;
   assign word_count    = wcnt_q;
   assign frame_done    = fdone_q;

endmodule

// File: tb/tb_owl_pixel_gearbox.sv
// Testbench for owl_pixel_gearbox: scoreboard of expected AXI-S words,
// table of frame lengths plus hand-written corner-case sequences.
module tb_owl_pixel_gearbox;

   localparam int unsigned DEPTH = 512;
   localparam int unsigned CW    = 16;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          new_frame;
   logic [47:0]   pixel;
   logic          data_vld;
   logic          capture_end;
   logic [63:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tuser;
   logic          m_axis_tlast;
   logic          overflow;
   logic [CW-1:0] word_count;
   logic          frame_done;

   owl_pixel_gearbox #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .new_frame     (new_frame),
      .pixel         (pixel),
      .data_vld      (data_vld),
      .capture_end   (capture_end),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tlast  (m_axis_tlast),
      .overflow      (overflow),
      .word_count    (word_count),
      .frame_done    (frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [63:0] data;
      logic        user;
      logic        last;
   } exp_t;

   typedef struct {
      int unsigned nbeats;
      int unsigned exp_wc;
   } vec_t;

   exp_t        exp_q[$];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          fd_seen = 0;
   int          rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

   // reference packer state
   logic [111:0] m_acc;
   int unsigned  m_nbits;
   exp_t         m_pend;
   bit           m_pend_v;
   bit           m_sof;
   int unsigned  m_wc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_push(input exp_t w);
      if (exp_q.size() < DEPTH) begin
         exp_q.push_back(w);
         m_wc++;
      end
   endtask

   task automatic model_form(input logic [63:0] d);
      exp_t w;
      if (m_pend_v) begin
         w = m_pend;
         w.last = 1'b0;
         model_push(w);
      end
      m_pend.data = d;
      m_pend.user = m_sof;
      m_pend.last = 1'b0;
      m_pend_v = 1'b1;
      m_sof = 1'b0;
   endtask

   task automatic model_new();
      m_acc = '0;
      m_nbits = 0;
      m_pend_v = 1'b0;
      m_sof = 1'b1;
      m_wc = 0;
   endtask

   task automatic model_beat(input logic [47:0] px);
      m_acc = m_acc | (112'(px) << m_nbits);
      m_nbits += 48;
      if (m_nbits >= 64) begin
         model_form(m_acc[63:0]);
         m_acc = m_acc >> 64;
         m_nbits -= 64;
      end
   endtask

   task automatic model_end();
      exp_t w;
      if (m_nbits > 0) model_form(m_acc[63:0]);
      m_acc = '0;
      m_nbits = 0;
      if (m_pend_v) begin
         w = m_pend;
         w.last = 1'b1;
         model_push(w);
      end
      m_pend_v = 1'b0;
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic start_frame(input bit with_beat, input logic [47:0] px);
      new_frame = 1'b1;
      capture_end = 1'b0;
      data_vld = with_beat;
      pixel = px;
      model_new();
      tick();
      new_frame = 1'b0;
      data_vld = 1'b0;
   endtask

   task automatic send_beat(input logic [47:0] px, input bit modeled);
      data_vld = 1'b1;
      pixel = px;
      if (modeled) model_beat(px);
      tick();
      data_vld = 1'b0;
   endtask

   task automatic end_capture(input bit modeled);
      tick();
      capture_end = 1'b1;
      if (modeled) model_end();
      repeat (5) tick();
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      chk("drain_words_left", 64'(exp_q.size()), 64'd0);
      repeat (3) tick();
      chk("tvalid_after_drain", 64'(m_axis_tvalid), 64'd0);
   endtask

   function automatic logic [47:0] pat(input int i);
      logic [47:0] k;
      k = 48'h111111111111;
      return 48'(i) * k;
   endfunction

   // tready driver
   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // output monitor: scoreboard pops, stall stability, frame_done counting
   logic        stall_prev = 1'b0;
   logic [63:0] prev_data;
   logic        prev_user, prev_last;
   always @(negedge sys_clk) begin
      exp_t e;
      if (sys_rst_n) begin
         if (stall_prev) begin
            chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("stall_tdata", m_axis_tdata, prev_data);
            chk("stall_tuser_tlast", {62'd0, m_axis_tuser, m_axis_tlast}, {62'd0, prev_user, prev_last});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL extra_word: got %h, expected no word (t=%0t)", m_axis_tdata, $time);
            end else begin
               e = exp_q.pop_front();
               chk("tdata", m_axis_tdata, e.data);
               chk("tuser", 64'(m_axis_tuser), 64'(e.user));
               chk("tlast", 64'(m_axis_tlast), 64'(e.last));
            end
         end
         stall_prev = m_axis_tvalid & ~m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_user  = m_axis_tuser;
         prev_last  = m_axis_tlast;
         if (frame_done) fd_seen++;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
      $fatal(1);
   end

   initial begin
      vec_t tbl[7];
      int   fd0;
      exp_t w;

      tbl[0] = '{nbeats: 0, exp_wc: 0};
      tbl[1] = '{nbeats: 1, exp_wc: 1};
      tbl[2] = '{nbeats: 2, exp_wc: 2};
      tbl[3] = '{nbeats: 4, exp_wc: 3};
      tbl[4] = '{nbeats: 5, exp_wc: 4};
      tbl[5] = '{nbeats: 7, exp_wc: 6};
      tbl[6] = '{nbeats: 8, exp_wc: 6};

      sys_rst_n = 1'b0;
      new_frame = 1'b0;
      data_vld = 1'b0;
      capture_end = 1'b0;
      pixel = '0;
      model_new();
      repeat (3) tick();
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tdata", m_axis_tdata, 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      chk("rst_overflow_fdone", {62'd0, overflow, frame_done}, 64'd0);
      sys_rst_n = 1'b1;
      tick();

      // 4-beat frame with fixed pattern, expectations written out by hand
      rdy_mode = 0;
      start_frame(1'b0, '0);
      w = '{data: 64'h1111_0000_0000_0000, user: 1'b1, last: 1'b0}; exp_q.push_back(w);
      w = '{data: 64'h2222_2222_1111_1111, user: 1'b0, last: 1'b0}; exp_q.push_back(w);
      w = '{data: 64'h3333_3333_3333_2222, user: 1'b0, last: 1'b1}; exp_q.push_back(w);
      fd0 = fd_seen;
      for (int i = 0; i < 4; i++) send_beat(pat(i), 1'b0);
      end_capture(1'b0);
      chk("t1_word_count", 64'(word_count), 64'd3);
      chk("t1_frame_done", 64'(fd_seen - fd0), 64'd1);
      wait_drain(100);

      // 3-beat frame: final word is the zero-extended 16-bit residue
      start_frame(1'b0, '0);
      w = '{data: 64'h1111_0000_0000_0000, user: 1'b1, last: 1'b0}; exp_q.push_back(w);
      w = '{data: 64'h2222_2222_1111_1111, user: 1'b0, last: 1'b0}; exp_q.push_back(w);
      w = '{data: 64'h0000_0000_0000_2222, user: 1'b0, last: 1'b1}; exp_q.push_back(w);
      fd0 = fd_seen;
      for (int i = 0; i < 3; i++) send_beat(pat(i), 1'b0);
      end_capture(1'b0);
      chk("t2_word_count", 64'(word_count), 64'd3);
      chk("t2_frame_done", 64'(fd_seen - fd0), 64'd1);
      wait_drain(100);

      // table of frame lengths with random pixels
      for (int r = 0; r < 7; r++) begin
         rdy_mode = (r % 2 == 0) ? 0 : 2;
         start_frame(1'b0, '0);
         fd0 = fd_seen;
         for (int unsigned b = 0; b < tbl[r].nbeats; b++)
            send_beat({16'($urandom), 32'($urandom)}, 1'b1);
         end_capture(1'b1);
         chk("tbl_word_count", 64'(word_count), 64'(tbl[r].exp_wc));
         chk("tbl_overflow", 64'(overflow), 64'd0);
         chk("tbl_frame_done", 64'(fd_seen - fd0), 64'd1);
         wait_drain(200);
      end

      // sink stalled through a 2*DEPTH-word frame
      rdy_mode = 1;
      tick();
      start_frame(1'b0, '0);
      fd0 = fd_seen;
      for (int b = 0; b < 1366; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b1);
      end_capture(1'b1);
      chk("ovf_overflow", 64'(overflow), 64'd1);
      chk("ovf_word_count", 64'(word_count), 64'(DEPTH));
      chk("ovf_model_count", 64'(m_wc), 64'(DEPTH));
      chk("ovf_frame_done", 64'(fd_seen - fd0), 64'd1);
      rdy_mode = 2;
      wait_drain(8 * DEPTH);
      chk("ovf_sticky", 64'(overflow), 64'd1);

      // frame aborted after 5 beats by new_frame, then a 4-beat frame
      rdy_mode = 0;
      start_frame(1'b0, '0);
      chk("abort_ovf_cleared", 64'(overflow), 64'd0);
      chk("abort_wc_cleared", 64'(word_count), 64'd0);
      fd0 = fd_seen;
      for (int b = 0; b < 5; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b1);
      tick();
      start_frame(1'b0, '0);
      for (int b = 0; b < 4; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b1);
      end_capture(1'b1);
      chk("abort_word_count", 64'(word_count), 64'd3);
      chk("abort_frame_done", 64'(fd_seen - fd0), 64'd1);
      wait_drain(100);

      // data_vld coincident with new_frame is dropped
      start_frame(1'b1, 48'hDEAD_BEEF_CAFE);
      for (int b = 0; b < 4; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b1);
      end_capture(1'b1);
      chk("coinc_word_count", 64'(word_count), 64'd3);
      wait_drain(100);

      // long frame with random ready, reset while draining
      rdy_mode = 2;
      start_frame(1'b0, '0);
      for (int b = 0; b < 1000; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b1);
      repeat (20) tick();
      chk("pre_reset_backlog", 64'(exp_q.size() > 0), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("async_rst_tdata", m_axis_tdata, 64'd0);
      chk("async_rst_tuser_tlast", {62'd0, m_axis_tuser, m_axis_tlast}, 64'd0);
      chk("async_rst_word_count", 64'(word_count), 64'd0);
      chk("async_rst_ovf_fdone", {62'd0, overflow, frame_done}, 64'd0);
      repeat (3) tick();
      sys_rst_n = 1'b1;
      tick();
      // beats in IDLE are ignored
      for (int b = 0; b < 4; b++) send_beat({16'($urandom), 32'($urandom)}, 1'b0);
      repeat (4) tick();
      chk("idle_word_count", 64'(word_count), 64'd0);
      chk("idle_tvalid", 64'(m_axis_tvalid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
